ex_alu_s1_core: RTL and testbench

EX_ALU_S1_CORE -- requirements
Module: ex_alu_s1

---
 rtl/ex_alu_s1_core.sv | 144 ++++++++++++++
 tb/tb_ex_alu_s1_core.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ex_alu_s1_core.sv
// Single-stage 64-bit execute ALU: combinational result plus a registered {Z,N,C,V} flag word.
// Only the flag register is clocked; the parent pipeline stage captures the result.
module ex_alu_s1_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] in1,
    input  logic [63:0] in2,
    input  logic        enable,
    input  logic [2:0]  unit,
    input  logic [1:0]  op,
    output logic [63:0] out,
    output logic [3:0]  flags_q
);

    localparam logic [2:0] UNIT_ARITH = 3'b000;
    localparam logic [2:0] UNIT_LOGIC = 3'b001;
    localparam logic [2:0] UNIT_SHIFT = 3'b010;
    localparam logic [2:0] UNIT_MOVE  = 3'b011;

    localparam logic [1:0] OP_0 = 2'b00;
    localparam logic [1:0] OP_1 = 2'b01;
    localparam logic [1:0] OP_2 = 2'b10;
    localparam logic [1:0] OP_3 = 2'b11;

    // Adder shared by ADD and SUB: subtract is in1 + ~in2 + 1, so carry=1 means no borrow.
    logic        is_sub;
    logic [63:0] add_b;
    logic [64:0] add_sum;
    logic        lt_signed;
    logic        lt_unsigned;

    assign is_sub      = op[0];
    assign add_b       = is_sub ? ~in2 : in2;
    assign add_sum     = {1'b0, in1} + {1'b0, add_b} + {64'd0, is_sub};
    assign lt_signed   = $signed(in1) < $signed(in2);
    assign lt_unsigned = in1 < in2;

    logic [63:0] arith_res;

    always_comb begin
        arith_res = '0;
        case (op)
            OP_0:    arith_res = add_sum[63:0];
            OP_1:    arith_res = add_sum[63:0];
            OP_2:    arith_res = {63'd0, lt_signed};
            OP_3:    arith_res = {63'd0, lt_unsigned};
            default: arith_res = '0;
        endcase
    end

    logic [63:0] logic_res;

    always_comb begin
        logic_res = '0;
        case (op)
            OP_0:    logic_res = in1 & in2;
            OP_1:    logic_res = in1 | in2;
            OP_2:    logic_res = in1 ^ in2;
            OP_3:    logic_res = ~(in1 | in2);
            default: logic_res = '0;
        endcase
    end

    // Rotate uses a doubled operand so the amount-0 case needs no special handling.
    logic [5:0]         shamt;
    logic signed [63:0] in1_s;
    logic [127:0]       rot_pair;
    logic [63:0]        sll_res;
    logic [63:0]        srl_res;
    logic [63:0]        sra_res;
    logic [63:0]        shift_res;

    assign shamt    = in2[5:0];
    assign in1_s    = in1;
    assign rot_pair = {in1, in1} >> shamt;
    assign sll_res  = in1 << shamt;
    assign srl_res  = in1 >> shamt;
    assign sra_res  = in1_s >>> shamt;

    always_comb begin
        shift_res = '0;
        case (op)
            OP_0:    shift_res = sll_res;
            OP_1:    shift_res = srl_res;
            OP_2:    shift_res = sra_res;
            OP_3:    shift_res = rot_pair[63:0];
            default: shift_res = '0;
        endcase
    end

    logic [63:0] move_res;

    always_comb begin
        move_res = '0;
        case (op)
            OP_0:    move_res = in1;
            OP_1:    move_res = in2;
            OP_2:    move_res = ~in1;
            OP_3:    move_res = 64'd0 - in1;
            default: move_res = '0;
        endcase
    end

    always_comb begin
        out = '0;
        if (enable) begin
            case (unit)
                UNIT_ARITH: out = arith_res;
                UNIT_LOGIC: out = logic_res;
                UNIT_SHIFT: out = shift_res;
                UNIT_MOVE:  out = move_res;
                default:    out = '0;
            endcase
        end
    end

    // Overflow: effective operands share a sign but the result does not.
    logic       is_addsub;
    logic       flag_z;
    logic       flag_n;
    logic       flag_c;
    logic       flag_v;
    logic [3:0] flags_d;

    assign is_addsub = (unit == UNIT_ARITH) && !op[1];
    assign flag_z    = (out == 64'd0);
    assign flag_n    = out[63];
    assign flag_c    = is_addsub && add_sum[64];
    assign flag_v    = is_addsub && (in1[63] == add_b[63]) && (add_sum[63] != in1[63]);

    always_comb begin
        flags_d = flags_q;
        if (!rst_n) begin
            flags_d = 4'b0000;
        end else if (enable) begin
            flags_d = {flag_z, flag_n, flag_c, flag_v};
        end
    end

    always_ff @(posedge clk) begin
        flags_q <= flags_d;
    end

endmodule

// File: tb/tb_ex_alu_s1_core.sv
// Directed and randomized checks of ex_alu_s1_core against a bit-level behavioural model.
module tb_ex_alu_s1_core;

    logic        clk;
    logic        rst_n;
    logic [63:0] in1;
    logic [63:0] in2;
    logic        enable;
    logic [2:0]  unit;
    logic [1:0]  op;
    logic [63:0] out;
    logic [3:0]  flags_q;

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_flags;

    ex_alu_s1_core dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in1     (in1),
        .in2     (in2),
        .enable  (enable),
        .unit    (unit),
        .op      (op),
        .out     (out),
        .flags_q (flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic en,
                                  input logic [2:0] u, input logic [1:0] o,
                                  output logic [63:0] r, output logic [3:0] f);
        logic               c;
        logic               v;
        logic signed [64:0] wide;
        int                 amt;
        r = 64'd0;
        c = 1'b0;
        v = 1'b0;
        amt = int'(b[5:0]);
        if (en) begin
            case (u)
                3'd0: case (o)
                    2'd0: begin
                        r = a + b;
                        c = (r < a);
                        wide = $signed({a[63], a}) + $signed({b[63], b});
                        v = (wide > 65'sd9223372036854775807) || (wide < -65'sd9223372036854775808);
                    end
                    2'd1: begin
                        r = a - b;
                        c = (a >= b);
                        wide = $signed({a[63], a}) - $signed({b[63], b});
                        v = (wide > 65'sd9223372036854775807) || (wide < -65'sd9223372036854775808);
                    end
                    2'd2: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
                    default: r = (a < b) ? 64'd1 : 64'd0;
                endcase
                3'd1: case (o)
                    2'd0: r = a & b;
                    2'd1: r = a | b;
                    2'd2: r = a ^ b;
                    default: r = ~(a | b);
                endcase
                3'd2: begin
                    r = a;
                    for (int k = 0; k < amt; k++) begin
                        case (o)
                            2'd0: r = {r[62:0], 1'b0};
                            2'd1: r = {1'b0, r[63:1]};
                            2'd2: r = {r[63], r[63:1]};
                            default: r = {r[0], r[63:1]};
                        endcase
                    end
                end
                3'd3: case (o)
                    2'd0: r = a;
                    2'd1: r = b;
                    2'd2: r = ~a;
                    default: r = (~a) + 64'd1;
                endcase
                default: r = 64'd0;
            endcase
        end
        f = {(r == 64'd0), r[63], c, v};
    endfunction

    // Apply one operation, check out and held flags mid-cycle, then check flags after the edge.
    task automatic step(input string tag, input logic rst_v, input logic en,
                        input logic [2:0] u, input logic [1:0] o,
                        input logic [63:0] a, input logic [63:0] b);
        logic [63:0] er;
        logic [3:0]  ef;
        rst_n = rst_v; enable = en; unit = u; op = o; in1 = a; in2 = b;
        model(a, b, en, u, o, er, ef);
        #1;
        total++;
        assert (out === er) else begin
            bad++;
            $error("FAIL %s out: got %h expected %h", tag, out, er);
        end
        total++;
        assert (flags_q === exp_flags) else begin
            bad++;
            $error("FAIL %s flags_hold: got %b expected %b", tag, flags_q, exp_flags);
        end
        @(posedge clk);
        #1;
        if (!rst_v) exp_flags = 4'b0000;
        else if (en) exp_flags = ef;
        total++;
        assert (flags_q === exp_flags) else begin
            bad++;
            $error("FAIL %s flags: got %b expected %b", tag, flags_q, exp_flags);
        end
    endtask

    task automatic check_const(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        logic [63:0] pick;
        rst_n = 1'b0; enable = 1'b0; unit = 3'd0; op = 2'd0; in1 = 64'd0; in2 = 64'd0;
        exp_flags = 4'b0000;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_const("reset_flags", {60'd0, flags_q}, 64'd0);
        check_const("reset_out", out, 64'd0);

        step("add_wrap", 1'b1, 1'b1, 3'd0, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        check_const("add_wrap_flags", {60'd0, flags_q}, {60'd0, 4'b1010});
        step("add_ovf", 1'b1, 1'b1, 3'd0, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        check_const("add_ovf_flags", {60'd0, flags_q}, {60'd0, 4'b0101});
        step("slt", 1'b1, 1'b1, 3'd0, 2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        check_const("slt_out", out, 64'd1);
        step("sltu", 1'b1, 1'b1, 3'd0, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        check_const("sltu_out", out, 64'd0);
        step("sub", 1'b1, 1'b1, 3'd0, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        check_const("sub_out", out, 64'hFFFF_FFFF_FFFF_FFFE);
        check_const("sub_carry", {63'd0, flags_q[1]}, 64'd1);
        step("sub_borrow", 1'b1, 1'b1, 3'd0, 2'd1, 64'd0, 64'd1);
        step("sub_ovf", 1'b1, 1'b1, 3'd0, 2'd1, 64'h8000_0000_0000_0000, 64'd1);

        step("sll", 1'b1, 1'b1, 3'd2, 2'd0, 64'h8000_0000_0000_0001, 64'h41);
        check_const("sll_out", out, 64'h2);
        step("srl", 1'b1, 1'b1, 3'd2, 2'd1, 64'h8000_0000_0000_0001, 64'h41);
        check_const("srl_out", out, 64'h4000_0000_0000_0000);
        step("sra", 1'b1, 1'b1, 3'd2, 2'd2, 64'h8000_0000_0000_0001, 64'h41);
        check_const("sra_out", out, 64'hC000_0000_0000_0000);
        step("ror", 1'b1, 1'b1, 3'd2, 2'd3, 64'h8000_0000_0000_0001, 64'h41);
        check_const("ror_out", out, 64'hC000_0000_0000_0000);
        step("ror_zero", 1'b1, 1'b1, 3'd2, 2'd3, 64'h8000_0000_0000_0001, 64'hFFC0);
        check_const("ror_zero_out", out, 64'h8000_0000_0000_0001);
        step("sra_63", 1'b1, 1'b1, 3'd2, 2'd2, 64'h8000_0000_0000_0000, 64'd63);
        step("sll_63", 1'b1, 1'b1, 3'd2, 2'd0, 64'h3, 64'd63);

        step("load_nz", 1'b1, 1'b1, 3'd3, 2'd3, 64'd5, 64'd0);
        step("en_off", 1'b1, 1'b0, 3'd0, 2'd0, 64'h1234, 64'h5678);
        check_const("en_off_out", out, 64'd0);
        step("reserved", 1'b1, 1'b1, 3'd5, 2'd1, 64'hDEAD_BEEF, 64'h1);
        check_const("reserved_flags", {60'd0, flags_q}, {60'd0, 4'b1000});
        step("load_nz2", 1'b1, 1'b1, 3'd0, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        step("rst_prio", 1'b0, 1'b1, 3'd1, 2'd1, 64'hF0, 64'h0F);
        check_const("rst_prio_out", out, 64'hFF);
        check_const("rst_prio_flags", {60'd0, flags_q}, 64'd0);
        step("resume", 1'b1, 1'b1, 3'd3, 2'd2, 64'd0, 64'd0);

        for (int i = 0; i < 400; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            pick = 64'($urandom_range(0, 7));
            if (pick == 64'd0) ra = 64'h8000_0000_0000_0000;
            if (pick == 64'd1) rb = ra;
            if (pick == 64'd2) rb = ~ra;
            step("rand", ($urandom_range(0, 19) != 0), ($urandom_range(0, 4) != 0),
                 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
